// File: rtl/ram_port_arbiter_if.sv
// Requester-side handshake bundle for ram_port_arbiter: one instance per port (CPU, host).
interface ram_req_if #(
  parameter int AW = 8,
  parameter int DW = 8
);
  logic          req;
  logic          wr;
  logic [AW-1:0] addr;
  logic [DW-1:0] wdata;
  logic          ack;
  logic [DW-1:0] rdata;

  modport master (output req, wr, addr, wdata, input ack, rdata);
  modport slave  (input req, wr, addr, wdata, output ack, rdata);
endinterface

// File: rtl/ram_port_arbiter.sv
// Two-port arbiter in front of a MAR-addressed RAM; turns each request into MAR-set then data phase.
// Optional macro RAM_ARB_RR_EN selects round-robin arbitration instead of fixed host-over-CPU priority.
module ram_port_arbiter #(
  parameter int AW          = 8,
  parameter int DW          = 8,
  parameter int HOLD_CYCLES = 1
) (
  input  logic          clk,
  input  logic          reset,
  ram_req_if.slave      c,
  ram_req_if.slave      h,
  output logic          busy,
  output logic [AW-1:0] bas,
  output logic          wsa,
  output logic [DW-1:0] bis,
  output logic          ws,
  output logic          we,
  input  logic [DW-1:0] bos
);

  typedef enum logic [1:0] {IDLE, ADDR, DATA, ACK} state_t;

  localparam logic [3:0] RELOAD = 4'(HOLD_CYCLES - 1);

  state_t        state;
  logic [3:0]    cnt;
  logic          sel_h;
  logic          op_wr;
  logic [DW-1:0] op_wdata;
  logic          grant_h;

`ifdef RAM_ARB_RR_EN
  logic last_h;
  // On a tie the port that was not granted last time wins.
  always_comb grant_h = h.req && (!c.req || !last_h);
`else
  always_comb grant_h = h.req;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      cnt      <= '0;
      sel_h    <= 1'b0;
      op_wr    <= 1'b0;
      op_wdata <= '0;
      busy     <= 1'b0;
      bas      <= '0;
      wsa      <= 1'b0;
      bis      <= '0;
      ws       <= 1'b0;
      we       <= 1'b0;
      c.ack    <= 1'b0;
      h.ack    <= 1'b0;
      c.rdata  <= '0;
      h.rdata  <= '0;
`ifdef RAM_ARB_RR_EN
      last_h   <= 1'b0;
`endif
    end else begin
      c.ack <= 1'b0;
      h.ack <= 1'b0;
      case (state)
        IDLE: begin
          if (c.req || h.req) begin
            sel_h    <= grant_h;
            op_wr    <= grant_h ? h.wr : c.wr;
            op_wdata <= grant_h ? h.wdata : c.wdata;
            bas      <= grant_h ? h.addr : c.addr;
            wsa      <= 1'b1;
            busy     <= 1'b1;
            cnt      <= RELOAD;
            state    <= ADDR;
`ifdef RAM_ARB_RR_EN
            last_h   <= grant_h;
`endif
          end
        end
        // MAR phase: bas already holds the latched address
        ADDR: begin
          if (cnt == 4'd0) begin
            wsa   <= 1'b0;
            bas   <= '0;
            cnt   <= RELOAD;
            state <= DATA;
            if (op_wr) begin
              ws  <= 1'b1;
              bis <= op_wdata;
            end else begin
              we  <= 1'b1;
            end
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        // Data phase: read data is taken on the final enable cycle
        DATA: begin
          if (cnt == 4'd0) begin
            ws    <= 1'b0;
            we    <= 1'b0;
            bis   <= '0;
            state <= ACK;
            if (sel_h) h.ack <= 1'b1;
            else       c.ack <= 1'b1;
            if (!op_wr) begin
              if (sel_h) h.rdata <= bos;
              else       c.rdata <= bos;
            end
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        ACK: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ram_port_arbiter.sv
// Randomized bench for ram_port_arbiter against a transaction-level model of arbitration and RAM.
module tb_ram_port_arbiter;

  localparam int HOLD = 3;

  logic       clk;
  logic       reset;
  logic       busy;
  logic [7:0] bas;
  logic       wsa;
  logic [7:0] bis;
  logic       ws;
  logic       we;
  logic [7:0] bos;

  ram_req_if #(.AW(8), .DW(8)) cif ();
  ram_req_if #(.AW(8), .DW(8)) hif ();

  ram_port_arbiter #(.AW(8), .DW(8), .HOLD_CYCLES(HOLD)) u_dut (
    .clk   (clk),
    .reset (reset),
    .c     (cif),
    .h     (hif),
    .busy  (busy),
    .bas   (bas),
    .wsa   (wsa),
    .bis   (bis),
    .ws    (ws),
    .we    (we),
    .bos   (bos)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Behavioural RAM behind the MAR interface
  logic [7:0] ram [0:255];
  logic [7:0] mar;
  always @(posedge clk) begin
    if (wsa) mar <= bas;
    if (ws)  ram[mar] <= bis;
  end
  assign bos = we ? ram[mar] : 8'h00;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Model state
  logic [7:0] exp_mem [0:255];
  logic       last_h;
  logic       cur_wr   [2];
  logic [7:0] cur_addr [2];
  logic [7:0] cur_data [2];

  // Bus monitor: invariants plus strobe/ack counters
  int         n_wsa = 0, n_ws = 0, n_we = 0, n_cack = 0, n_hack = 0;
  logic [7:0] last_bas = 8'h00;
  logic [7:0] last_bis = 8'h00;
  always @(negedge clk) begin
    check("strobe_excl", ((32'(wsa) + 32'(ws) + 32'(we)) > 32'd1) ? 32'd1 : 32'd0, 32'd0);
    check("bas_outside_addr", wsa ? 32'd0 : 32'(bas), 32'd0);
    check("bis_outside_write", ws ? 32'd0 : 32'(bis), 32'd0);
    check("ack_excl", 32'(cif.ack & hif.ack), 32'd0);
    if (wsa) begin n_wsa <= n_wsa + 1; last_bas <= bas; end
    if (ws)  begin n_ws  <= n_ws + 1;  last_bis <= bis; end
    if (we)  n_we <= n_we + 1;
    if (cif.ack) n_cack <= n_cack + 1;
    if (hif.ack) n_hack <= n_hack + 1;
  end

  task automatic load_txn(input int p);
    cur_wr[p]   = 1'($urandom_range(0, 1));
    cur_addr[p] = 8'($urandom_range(0, 15));
    cur_data[p] = 8'($urandom_range(0, 255));
    if (p == 0) begin
      cif.wr = cur_wr[p]; cif.addr = cur_addr[p]; cif.wdata = cur_data[p]; cif.req = 1'b1;
    end else begin
      hif.wr = cur_wr[p]; hif.addr = cur_addr[p]; hif.wdata = cur_data[p]; hif.req = 1'b1;
    end
  endtask

  // Both ports hold req for nc / nh back-to-back transactions, raised together.
  task automatic run_stream(input int nc, input int nh);
    int rem [2];
    int exp_p, got_p, lat, lat_exp;
    int s_wsa, s_ws, s_we;
    logic [7:0] got_rd;
    rem[0] = nc;
    rem[1] = nh;
    @(negedge clk);
    s_wsa = n_wsa; s_ws = n_ws; s_we = n_we;
    for (int p = 0; p < 2; p++) if (rem[p] > 0) load_txn(p);
    lat_exp = 2 * HOLD + 1;
    while (rem[0] > 0 || rem[1] > 0) begin
      if (rem[0] > 0 && rem[1] > 0) begin
`ifdef RAM_ARB_RR_EN
        exp_p = last_h ? 0 : 1;
`else
        exp_p = 1;
`endif
      end else begin
        exp_p = (rem[1] > 0) ? 1 : 0;
      end
      got_p = -1;
      lat   = 0;
      while (got_p < 0 && lat < 64) begin
        @(posedge clk); #1;
        lat++;
        if (cif.ack)      got_p = 0;
        else if (hif.ack) got_p = 1;
      end
      if (got_p < 0) begin
        check("ack_timeout", 32'd0, 32'd1);
        cif.req = 1'b0;
        hif.req = 1'b0;
        return;
      end
      check("winner", 32'(got_p), 32'(exp_p));
      check("latency", 32'(lat), 32'(lat_exp));
      check("busy_at_ack", 32'(busy), 32'd1);
      check("wsa_cycles", 32'(n_wsa - s_wsa), 32'(HOLD));
      check("bas_addr", 32'(last_bas), 32'(cur_addr[exp_p]));
      if (cur_wr[exp_p]) begin
        check("ws_cycles", 32'(n_ws - s_ws), 32'(HOLD));
        check("we_on_write", 32'(n_we - s_we), 32'd0);
        check("bis_data", 32'(last_bis), 32'(cur_data[exp_p]));
        exp_mem[cur_addr[exp_p]] = cur_data[exp_p];
      end else begin
        check("ws_on_read", 32'(n_ws - s_ws), 32'd0);
        check("we_cycles", 32'(n_we - s_we), 32'(HOLD));
        got_rd = (exp_p == 0) ? cif.rdata : hif.rdata;
        check("rdata", 32'(got_rd), 32'(exp_mem[cur_addr[exp_p]]));
      end
      last_h = (exp_p == 1);
      s_wsa = n_wsa; s_ws = n_ws; s_we = n_we;
      rem[exp_p]--;
      if (rem[exp_p] > 0) load_txn(exp_p);
      else if (exp_p == 0) cif.req = 1'b0;
      else hif.req = 1'b0;
      lat_exp = 2 * HOLD + 2;
    end
    repeat (2) @(negedge clk);
  endtask

  initial begin
    int lat, acks_before;
    for (int a = 0; a < 256; a++) begin
      ram[a]     = 8'h00;
      exp_mem[a] = 8'h00;
    end
    last_h = 1'b0;
    cif.req = 1'b0; cif.wr = 1'b0; cif.addr = 8'h00; cif.wdata = 8'h00;
    hif.req = 1'b0; hif.wr = 1'b0; hif.addr = 8'h00; hif.wdata = 8'h00;
    reset = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_strobes", 32'({wsa, ws, we}), 32'd0);
    check("rst_bas", 32'(bas), 32'd0);
    check("rst_bis", 32'(bis), 32'd0);
    check("rst_acks", 32'({cif.ack, hif.ack}), 32'd0);
    check("rst_rdata", 32'({cif.rdata, hif.rdata}), 32'd0);
    reset = 1'b0;
    repeat (2) @(negedge clk);

    // CPU write 0x2A to 0x05; address and data changed after grant must be ignored
    cif.wr = 1'b1; cif.addr = 8'h05; cif.wdata = 8'h2A; cif.req = 1'b1;
    lat = 0;
    while (!cif.ack && !hif.ack && lat < 64) begin
      @(posedge clk); #1;
      lat++;
      if (lat == 1) begin cif.addr = 8'h06; cif.wdata = 8'h11; end
    end
    check("t1_c_ack", 32'(cif.ack), 32'd1);
    check("t1_latency", 32'(lat), 32'(2 * HOLD + 1));
    check("t1_bas", 32'(last_bas), 32'h05);
    check("t1_bis", 32'(last_bis), 32'h2A);
    cif.req = 1'b0;
    exp_mem[5] = 8'h2A;
    last_h = 1'b0;
    repeat (2) @(negedge clk);
    check("t1_ram5", 32'(ram[5]), 32'h2A);
    check("t1_ram6", 32'(ram[6]), 32'(exp_mem[6]));

    // Both ports hold req for three transactions each
    run_stream(3, 3);

    for (int i = 0; i < 40; i++) begin
      int nc, nh;
      nc = int'($urandom_range(0, 3));
      nh = int'($urandom_range(0, 3));
      if (nc == 0 && nh == 0) nc = 1;
      run_stream(nc, nh);
    end

    // Reset during the data phase of a write: strobe drops at once, no ack
    acks_before = n_cack + n_hack;
    @(negedge clk);
    cif.wr = 1'b1; cif.addr = 8'h09; cif.wdata = 8'h55; cif.req = 1'b1;
    lat = 0;
    while (!ws && lat < 32) begin
      @(posedge clk); #1;
      lat++;
    end
    check("t5_ws_seen", 32'(ws), 32'd1);
    @(negedge clk);
    reset = 1'b1;
    #1;
    check("t5_ws_drop", 32'(ws), 32'd0);
    check("t5_busy", 32'(busy), 32'd0);
    check("t5_strobes", 32'({wsa, we}), 32'd0);
    cif.req = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    last_h = 1'b0;
    repeat (12) @(negedge clk);
    check("t5_no_ack", 32'(n_cack + n_hack), 32'(acks_before));

    run_stream(2, 2);
    run_stream(1, 0);

    for (int a = 0; a < 16; a++) check("ram_final", 32'(ram[a]), 32'(exp_mem[a]));

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
